// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers up to 63 payload bytes, then frames them as
// header / payload / parity toward a router input that may stall via busy.
module router_pkt_tx (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic [1:0] dest_addr,
  input  logic       start,
  input  logic       corrupt_parity,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       cfg_err,
  output logic       wr_ovf
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned DEPTH  = 63;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   par_q, par_d;
  logic                corrupt_q, corrupt_d;
  logic [DATA_W-1:0]   data_d;
  logic                pkt_valid_d;
  logic                tx_active_d;
  logic                done_d;
  logic                cfg_err_d;
  logic                wr_ovf_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_full;
  logic                mem_we;
  logic                last_byte;
  logic [CNT_W-1:0]    nxt_idx;
  logic [DATA_W-1:0]   hdr;

  assign wr_full   = (wr_cnt_q == CNT_W'(DEPTH));
  assign mem_we    = (state_q == IDLE) && wr_en && !wr_full && !reset;
  assign last_byte = (rd_idx_q == len_q - CNT_W'(1));
  assign nxt_idx   = rd_idx_q + CNT_W'(1);
  assign hdr       = {wr_cnt_q, dest_addr};

  // Payload storage; contents survive reset and are simply overwritten.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_cnt_q] <= wr_data;
    end
  end

  // Next-state and next-output logic; parity folds in each byte as it is loaded.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_idx_d    = rd_idx_q;
    len_d       = len_q;
    par_d       = par_q;
    corrupt_d   = corrupt_q;
    data_d      = data_out;
    pkt_valid_d = pkt_valid;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    wr_ovf_d    = wr_ovf;

    case (state_q)
      IDLE: begin
        if (wr_en) begin
          if (wr_full) begin
            wr_ovf_d = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end
        // Length is the count before any same-cycle write.
        if (start) begin
          if ((wr_cnt_q == '0) || (dest_addr == 2'b11)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = HEADER;
            pkt_valid_d = 1'b1;
            data_d      = hdr;
            par_d       = hdr;
            len_d       = wr_cnt_q;
            rd_idx_d    = '0;
            corrupt_d   = corrupt_parity;
          end
        end
      end

      HEADER: begin
        if (!busy) begin
          state_d = PAYLOAD;
          data_d  = mem[rd_idx_q];
          par_d   = par_q ^ mem[rd_idx_q];
        end
      end

      PAYLOAD: begin
        if (!busy) begin
          if (last_byte) begin
            state_d     = PARITY;
            pkt_valid_d = 1'b0;
            data_d      = par_q ^ {DATA_W{corrupt_q}};
          end else begin
            rd_idx_d = nxt_idx;
            data_d   = mem[nxt_idx];
            par_d    = par_q ^ mem[nxt_idx];
          end
        end
      end

      PARITY: begin
        if (!busy) begin
          state_d  = GAP;
          data_d   = '0;
          done_d   = 1'b1;
          wr_cnt_d = '0;
          wr_ovf_d = 1'b0;
          rd_idx_d = '0;
          par_d    = '0;
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        pkt_valid_d = 1'b0;
      end
    endcase

    tx_active_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      rd_idx_q  <= '0;
      len_q     <= '0;
      par_q     <= '0;
      corrupt_q <= 1'b0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      wr_ovf    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_idx_q  <= rd_idx_d;
      len_q     <= len_d;
      par_q     <= par_d;
      corrupt_q <= corrupt_d;
      data_out  <= data_d;
      pkt_valid <= pkt_valid_d;
      tx_active <= tx_active_d;
      done      <= done_d;
      cfg_err   <= cfg_err_d;
      wr_ovf    <= wr_ovf_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed vector table, hand sequences, and random
// packets checked against a byte-stream model of the framed packet.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [1:0] dest_addr = 2'd0;
  logic       start = 1'b0;
  logic       corrupt_parity = 1'b0;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       cfg_err;
  logic       wr_ovf;

  router_pkt_tx dut (
    .clock          (clock),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .dest_addr      (dest_addr),
    .start          (start),
    .corrupt_parity (corrupt_parity),
    .busy           (busy),
    .pkt_valid      (pkt_valid),
    .data_out       (data_out),
    .tx_active      (tx_active),
    .done           (done),
    .cfg_err        (cfg_err),
    .wr_ovf         (wr_ovf)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: bytes currently buffered and the sticky overflow flag.
  logic [7:0] mbuf[$];
  logic       movf = 1'b0;

  typedef struct {
    logic       rst, we;
    logic [7:0] wd;
    logic [1:0] da;
    logic       st, cp, bz;
    logic       pv;
    logic [7:0] dout;
    logic       dchk, txa, dn, ce, ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic we, input logic [7:0] wd,
                              input logic [1:0] da, input logic st, input logic cp,
                              input logic bz, input logic pv, input logic [7:0] dout,
                              input logic dchk, input logic txa, input logic dn,
                              input logic ce, input logic ov);
    vec_t v;
    v.rst = rst; v.we = we; v.wd = wd; v.da = da; v.st = st; v.cp = cp; v.bz = bz;
    v.pv = pv; v.dout = dout; v.dchk = dchk; v.txa = txa; v.dn = dn; v.ce = ce; v.ov = ov;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", name, act, exp);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h required %02h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_write(input logic [7:0] b);
    if (mbuf.size() == 63) movf = 1'b1;
    else mbuf.push_back(b);
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; busy = 1'b0;
    tick();
    reset = 1'b0;
    mbuf.delete();
    movf = 1'b0;
    chk1("rst_pv", pkt_valid, 1'b0);
    chk8("rst_data", data_out, 8'h00);
    chk1("rst_txa", tx_active, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_cfg", cfg_err, 1'b0);
    chk1("rst_ovf", wr_ovf, 1'b0);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
    model_write(b);
    chk1("wr_ovf", wr_ovf, movf);
    chk1("wr_pv", pkt_valid, 1'b0);
    chk1("wr_txa", tx_active, 1'b0);
  endtask

  // Launch a packet and follow it to the end, with optional busy stalls and
  // ignored write/start noise while the transmitter is active.
  task automatic send_packet(input logic [1:0] da, input logic cp, input logic same_wr,
                             input logic [7:0] same_data, input logic noisy);
    int         len;
    int         idx;
    int         cyc;
    logic       bz;
    logic [7:0] par;
    logic [7:0] hdr;
    logic [7:0] exp_d[$];
    logic       exp_v[$];
    len = mbuf.size();
    start = 1'b1; dest_addr = da; corrupt_parity = cp; wr_en = same_wr; wr_data = same_data;
    tick();
    start = 1'b0; wr_en = 1'b0; corrupt_parity = 1'b0;
    if (same_wr) model_write(same_data);
    if (len == 0 || da == 2'b11) begin
      chk1("rej_cfg", cfg_err, 1'b1);
      chk1("rej_pv", pkt_valid, 1'b0);
      chk1("rej_txa", tx_active, 1'b0);
      tick();
      chk1("rej_cfg_clr", cfg_err, 1'b0);
      chk1("rej_txa2", tx_active, 1'b0);
      chk1("rej_ovf", wr_ovf, movf);
      return;
    end
    hdr = {6'(len), da};
    exp_d.push_back(hdr); exp_v.push_back(1'b1);
    par = hdr;
    for (int i = 0; i < len; i++) begin
      exp_d.push_back(mbuf[i]); exp_v.push_back(1'b1);
      par = par ^ mbuf[i];
    end
    exp_d.push_back(cp ? ~par : par); exp_v.push_back(1'b0);
    idx = 0;
    cyc = 0;
    while (idx < exp_d.size() && cyc < 2000) begin
      chk8($sformatf("byte%0d_data", idx), data_out, exp_d[idx]);
      chk1($sformatf("byte%0d_pv", idx), pkt_valid, exp_v[idx]);
      chk1("act_txa", tx_active, 1'b1);
      chk1("act_done", done, 1'b0);
      chk1("act_ovf", wr_ovf, movf);
      bz = noisy && ($urandom_range(0, 2) == 0);
      busy = bz;
      if (noisy) begin
        wr_en = 1'($urandom_range(0, 1));
        wr_data = 8'($urandom);
        start = 1'($urandom_range(0, 1));
        dest_addr = 2'($urandom);
      end
      tick();
      if (!bz) idx++;
      cyc++;
    end
    busy = 1'b0; wr_en = 1'b0; start = 1'b0;
    if (idx < exp_d.size()) begin
      n_checks++;
      $display("FAIL stream_timeout: got %0d bytes required %0d", idx, exp_d.size());
    end
    mbuf.delete();
    movf = 1'b0;
    chk1("gap_done", done, 1'b1);
    chk1("gap_pv", pkt_valid, 1'b0);
    chk1("gap_txa", tx_active, 1'b1);
    chk1("gap_ovf", wr_ovf, 1'b0);
    tick();
    chk1("post_done", done, 1'b0);
    chk1("post_txa", tx_active, 1'b0);
    chk1("post_pv", pkt_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    // Basic packet A5,5A,FF to port 1.
    tbl.push_back(mk(1,0,8'h00,2'd0,0,0,0, 0,8'h00,1,0,0,0,0));
    tbl.push_back(mk(0,1,8'hA5,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,1,8'h5A,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,1,8'hFF,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd1,1,0,0, 1,8'h0D,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 1,8'hA5,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 1,8'h5A,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 1,8'hFF,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'h0D,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'h00,0,1,1,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    // Same packet, 0x5A stalled two cycles; start/write during stall ignored.
    tbl.push_back(mk(0,1,8'hA5,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,1,8'h5A,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,1,8'hFF,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd1,1,0,0, 1,8'h0D,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 1,8'hA5,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 1,8'h5A,1,1,0,0,0));
    tbl.push_back(mk(0,1,8'hEE,2'd2,1,0,1, 1,8'h5A,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,1, 1,8'h5A,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 1,8'hFF,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'h0D,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'h00,0,1,1,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    // Rejected starts: empty buffer, then dest 3.
    tbl.push_back(mk(0,0,8'h00,2'd1,1,0,0, 0,8'h00,0,0,0,1,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,1,8'h77,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd3,1,0,0, 0,8'h00,0,0,0,1,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    // Corrupted parity.
    tbl.push_back(mk(1,0,8'h00,2'd0,0,0,0, 0,8'h00,1,0,0,0,0));
    tbl.push_back(mk(0,1,8'hA5,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,1,8'h5A,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,1,8'hFF,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd1,1,1,0, 1,8'h0D,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 1,8'hA5,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 1,8'h5A,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 1,8'hFF,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'hF2,1,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'h00,0,1,1,0,0));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,0,0, 0,8'h00,0,0,0,0,0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; wr_en = tbl[i].we; wr_data = tbl[i].wd; dest_addr = tbl[i].da;
      start = tbl[i].st; corrupt_parity = tbl[i].cp; busy = tbl[i].bz;
      tick();
      chk1($sformatf("t%0d_pv", i), pkt_valid, tbl[i].pv);
      chk1($sformatf("t%0d_txa", i), tx_active, tbl[i].txa);
      chk1($sformatf("t%0d_done", i), done, tbl[i].dn);
      chk1($sformatf("t%0d_cfg", i), cfg_err, tbl[i].ce);
      chk1($sformatf("t%0d_ovf", i), wr_ovf, tbl[i].ov);
      if (tbl[i].dchk) chk8($sformatf("t%0d_data", i), data_out, tbl[i].dout);
    end
    reset = 1'b0; wr_en = 1'b0; start = 1'b0; corrupt_parity = 1'b0; busy = 1'b0;

    // Overflow: 64 writes, full-length packet, flag clears on GAP.
    do_reset();
    for (int i = 0; i < 64; i++) write_byte(8'(i * 7 + 3));
    chk1("ovf_after64", wr_ovf, 1'b1);
    send_packet(2'd2, 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset during second payload byte, then a fresh packet.
    do_reset();
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    start = 1'b1; dest_addr = 2'd2;
    tick();
    start = 1'b0;
    chk8("mid_hdr", data_out, 8'h0E);
    tick();
    chk8("mid_p0", data_out, 8'h11);
    tick();
    chk8("mid_p1", data_out, 8'h22);
    chk1("mid_p1_pv", pkt_valid, 1'b1);
    do_reset();
    write_byte(8'h44); write_byte(8'h55);
    send_packet(2'd0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Start together with a write: the write is stored but not sent.
    write_byte(8'h10); write_byte(8'h20);
    send_packet(2'd1, 1'b0, 1'b1, 8'h30, 1'b0);

    // Random packets.
    for (int p = 0; p < 40; p++) begin
      int n;
      n = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) n = $urandom_range(60, 66);
      for (int i = 0; i < n; i++) write_byte(8'($urandom));
      send_packet(2'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 8'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: wr_en  input  1  payload byte write strobe, honoured in IDLE only.
REQ-004 SHALL have port: wr_data  input  8  payload byte written into internal buffer.
REQ-005 SHALL have port: dest_addr  input  2  destination port, sampled on start.
REQ-006 SHALL have port: start  input  1  one-cycle request to transmit buffered payload.
REQ-007 SHALL have port: corrupt_parity  input  1  sampled on start; inverts transmitted parity byte.
REQ-008 SHALL have port: busy  input  1  router stall; current byte not consumed while high.
REQ-009 SHALL have port: pkt_valid  output  1  high during header and payload bytes, low otherwise.
REQ-010 SHALL have port: data_out  output  8  registered byte to router input.
REQ-011 SHALL have port: tx_active  output  1  high in any state other than IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle pulse after parity byte consumed.
REQ-013 SHALL have port: cfg_err  output  1  one-cycle pulse on rejected start.
REQ-014 SHALL have port: wr_ovf  output  1  sticky: write attempted with buffer holding 63 bytes.

Function
REQ-015 SHALL contain a 63x8 payload buffer with 6-bit write count wr_cnt; each IDLE wr_en stores wr_data at index wr_cnt and increments wr_cnt.
REQ-016 SHALL drop wr_en when wr_cnt==63 and set wr_ovf; wr_en outside IDLE SHALL be ignored with no flag.
REQ-017 SHALL use FSM states IDLE, HEADER, PAYLOAD, PARITY, GAP.
REQ-018 SHALL, on start in IDLE with wr_cnt==0 or dest_addr==2'b11, pulse cfg_err next cycle and remain IDLE; buffer and wr_cnt kept.
REQ-019 SHALL, on valid start in IDLE at edge k, present HEADER from cycle k+1: pkt_valid=1, data_out={wr_cnt[5:0],dest_addr}.
REQ-020 SHALL treat the current byte as consumed at any edge where busy==0 in HEADER/PAYLOAD/PARITY; while busy==1 data_out, pkt_valid and state SHALL hold.
REQ-021 SHALL, after header consumed, output buffer bytes index 0..len-1 in PAYLOAD with pkt_valid=1, one per consumed cycle, no bubbles.
REQ-022 SHALL, after last payload byte consumed, enter PARITY: pkt_valid=0, data_out = XOR of header and all payload bytes, bitwise-inverted if corrupt_parity was sampled 1.
REQ-023 SHALL, on parity consumed, enter GAP for exactly one cycle with pkt_valid=0, done=1, wr_cnt and wr_ovf cleared, then return to IDLE.
REQ-024 SHALL ignore start while not IDLE; start and wr_en in the same IDLE cycle: write SHALL be accepted and excluded from the launched packet length.
REQ-025 SHALL compute parity incrementally as bytes are loaded, giving no extra latency; transfer takes len+2 unstalled cycles plus one GAP cycle.
REQ-026 SHALL guarantee pkt_valid low for at least two consecutive cycles (PARITY, GAP) between packets.

Reset
REQ-027 SHALL, while reset high at an edge, force IDLE, pkt_valid=0, data_out=0x00, done=0, cfg_err=0, wr_ovf=0, wr_cnt=0, parity accumulator=0, regardless of state.
REQ-028 SHALL, on reset mid-packet, drop pkt_valid the following cycle with no parity byte emitted; buffer contents need not be cleared.

Verification
REQ-029 SHALL pass: write A5,5A,FF; start dest_addr=1, busy=0 -> data_out 0x0D(pv=1),A5,5A,FF(pv=1),0x0D(pv=0), then done pulse.
REQ-030 SHALL pass: same packet, busy=1 for 2 cycles while 0x5A presented -> 0x5A held 3 cycles, pkt_valid stays 1, sequence otherwise unchanged.
REQ-031 SHALL pass: start with dest_addr=3 (or no writes) -> cfg_err=1 one cycle, pkt_valid never rises, tx_active stays 0.
REQ-032 SHALL pass: REQ-029 stimulus with corrupt_parity=1 -> parity byte 0xF2, done still pulses.
REQ-033 SHALL pass: 64 writes -> wr_ovf=1, header 0xFC|addr, 63 payload bytes sent; wr_ovf clears on GAP.
REQ-034 SHALL pass: reset asserted during second payload byte -> next cycle pkt_valid=0, data_out=0x00, IDLE; new packet then transmits correctly.
